rx_fifo_read_arbiter: RTL and testbench

RX_FIFO_READ_ARBITER -- requirements
Module: rx_fifo_read_arbiter

---
 rtl/rx_fifo_arb_pkg.sv | 15 +
 rtl/rr_pick2.sv | 24 ++
 rtl/rx_fifo_read_arbiter.sv | 113 +++++++++++
 tb/tb_rx_fifo_read_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_fifo_arb_pkg.sv
// Shared definitions for the RX FIFO read arbiter.
//   NUM_REQ : number of requesters sharing the FIFO read port
//   state_e : read FSM states (idle, pop strobe, data capture, delivery)
package rx_fifo_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2,
    DELIVER = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection (purely combinational).
//   req_i  : per-requester request levels
//   last_i : index of the requester served most recently
//   win_o  : one-hot winner, all-zero when nobody requests
module rr_pick2
  import rx_fifo_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  output logic [NUM_REQ-1:0] win_o
);

  always_comb begin
    win_o = '0;
    unique case (req_i)
      2'b01:   win_o = 2'b01;
      2'b10:   win_o = 2'b10;
      // Contention: the requester that was not served last goes first.
      2'b11:   win_o = last_i ? 2'b01 : 2'b10;
      default: win_o = '0;
    endcase
  end

endmodule

// File: rtl/rx_fifo_read_arbiter.sv
// Arbitrates two byte requesters onto one registered-output RX FIFO.
// One byte is popped, captured and held on rd_data until the granted
// requester acknowledges it; per-requester saturating counters track
// delivered bytes.
//   clk, rst        : clock, asynchronous active-high reset
//   fifo_empty      : FIFO empty flag
//   fifo_data       : FIFO read data, valid the cycle after an accepted pop
//   fifo_data_rdy   : FIFO write strobe (FIFO ignores pop while high)
//   bist_mode       : FIFO BIST mode (FIFO ignores pop while high)
//   fifo_pop        : pop strobe to the FIFO
//   req             : per-requester level request
//   gnt             : one-hot grant, qualifies rd_valid
//   rd_data         : delivered byte
//   rd_valid        : byte available to the granted requester
//   rd_ack          : per-requester acceptance
//   cnt0, cnt1      : saturating bytes-delivered counters
module rx_fifo_read_arbiter
  import rx_fifo_arb_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  input  logic                 fifo_data_rdy,
  input  logic                 bist_mode,
  output logic                 fifo_pop,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  input  logic [NUM_REQ-1:0]   rd_ack,
  output logic [CNT_BITS-1:0]  cnt0,
  output logic [CNT_BITS-1:0]  cnt1
);

  state_e               state_q;
  logic [NUM_REQ-1:0]   win_q;      // winner latched when leaving IDLE
  logic                 last_q;     // index of last served requester
  logic [DATA_BITS-1:0] rd_data_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [CNT_BITS-1:0]  cnt0_q;
  logic [CNT_BITS-1:0]  cnt1_q;

  logic [NUM_REQ-1:0]   win_d;
  logic                 pop_blocked;
  logic                 ack_hit;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + {{(CNT_BITS-1){1'b0}}, 1'b1};
  endfunction

  rr_pick2 u_pick (
    .req_i  (req),
    .last_i (last_q),
    .win_o  (win_d)
  );

  // The FIFO silently drops a pop while it is being written or in BIST.
  assign pop_blocked = fifo_data_rdy | bist_mode;
  // Only the acknowledge bit of the current grantee counts.
  assign ack_hit     = |(rd_ack & gnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= '0;
      last_q    <= 1'b1;
      rd_data_q <= '0;
      gnt_q     <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if ((req != '0) && !fifo_empty && !bist_mode) begin
            state_q <= POP;
            win_q   <= win_d;
          end
        end
        POP: begin
          // Keep the strobe up until the FIFO can actually take it.
          if (!pop_blocked) state_q <= CAPTURE;
        end
        CAPTURE: begin
          rd_data_q <= fifo_data;
          gnt_q     <= win_q;
          state_q   <= DELIVER;
        end
        DELIVER: begin
          if (ack_hit) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= gnt_q[1];
            if (gnt_q[0]) cnt0_q <= sat_inc(cnt0_q);
            else          cnt1_q <= sat_inc(cnt1_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_pop = (state_q == POP);
  assign rd_valid = (state_q == DELIVER);
  assign gnt      = gnt_q;
  assign rd_data  = rd_data_q;
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;

endmodule

// File: tb/tb_rx_fifo_read_arbiter.sv
// Randomised scoreboard bench for rx_fifo_read_arbiter with a queue-based
// FIFO model and a transaction-level arbitration/counter reference model.
module tb_rx_fifo_read_arbiter;

  localparam int DATA_BITS = 8;
  localparam int CNT_BITS  = 4;
  localparam int CMAX      = (1 << CNT_BITS) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 fifo_empty = 1'b1;
  logic [DATA_BITS-1:0] fifo_data  = '0;
  logic                 fifo_data_rdy;
  logic                 bist_mode;
  logic                 fifo_pop;
  logic [1:0]           req;
  logic [1:0]           gnt;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic [1:0]           rd_ack;
  logic [CNT_BITS-1:0]  cnt0;
  logic [CNT_BITS-1:0]  cnt1;
  logic [DATA_BITS-1:0] wdata;

  always #5 clk = ~clk;

  rx_fifo_read_arbiter #(.DATA_BITS(DATA_BITS), .CNT_BITS(CNT_BITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_data_rdy (fifo_data_rdy),
    .bist_mode     (bist_mode),
    .fifo_pop      (fifo_pop),
    .req           (req),
    .gnt           (gnt),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ack        (rd_ack),
    .cnt0          (cnt0),
    .cnt1          (cnt1)
  );

  typedef struct packed {
    logic [1:0]           win;
    logic [DATA_BITS-1:0] data;
    logic [CNT_BITS-1:0]  c0;
    logic [CNT_BITS-1:0]  c1;
  } exp_t;

  exp_t                 sb[$];        // expected deliveries, in order
  logic [DATA_BITS-1:0] fq[$];        // physical FIFO contents
  logic [DATA_BITS-1:0] exp_bytes[$]; // bytes not yet assigned to a delivery
  int   n_chk  = 0;
  int   n_fail = 0;
  logic m_last;
  int   m_c0, m_c1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // FIFO model: write has priority, pop ignored while writing or in BIST.
  always @(posedge clk) begin
    if (fifo_data_rdy) fq.push_back(wdata);
    else if (fifo_pop && !bist_mode && fq.size() > 0) fifo_data <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  // Reference model: decide the winner, byte and resulting counters.
  task automatic predict(input logic [1:0] r);
    exp_t e;
    int   w;
    if (r == 2'b11) w = m_last ? 0 : 1;
    else            w = r[1] ? 1 : 0;
    m_last = (w == 1);
    if (w == 0) m_c0 = (m_c0 == CMAX) ? m_c0 : m_c0 + 1;
    else        m_c1 = (m_c1 == CMAX) ? m_c1 : m_c1 + 1;
    e.win  = (w == 0) ? 2'b01 : 2'b10;
    e.data = exp_bytes.pop_front();
    e.c0   = CNT_BITS'(m_c0);
    e.c1   = CNT_BITS'(m_c1);
    sb.push_back(e);
  endtask

  // Monitor: compares every offered byte against the scoreboard.
  exp_t cur;
  bit   prev_v  = 1'b0;
  bit   cnt_pend = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_v   = 1'b0;
      cnt_pend = 1'b0;
    end else begin
      if (cnt_pend) begin
        chk("cnt0_after_ack", cnt0, cur.c0);
        chk("cnt1_after_ack", cnt1, cur.c1);
        cnt_pend = 1'b0;
      end
      if (rd_valid) begin
        if (!prev_v) begin
          chk("sb_has_entry_at_valid", (sb.size() > 0), 1);
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("gnt_at_valid", gnt, cur.win);
            chk("rd_data_at_valid", rd_data, cur.data);
          end
        end else begin
          chk("gnt_hold", gnt, cur.win);
          chk("rd_data_hold", rd_data, cur.data);
        end
        if ((rd_ack & cur.win) != 2'b00) cnt_pend = 1'b1;
      end else begin
        chk("gnt_zero_when_not_valid", gnt, 0);
      end
      prev_v = rd_valid;
    end
  end

  // All stimulus tasks enter and leave just after a falling edge.
  task automatic write_byte(input logic [DATA_BITS-1:0] b);
    fifo_data_rdy = 1'b1;
    wdata         = b;
    exp_bytes.push_back(b);
    @(negedge clk);
    #1;
    fifo_data_rdy = 1'b0;
  endtask

  task automatic reset_tail();
    m_last = 1'b1;
    m_c0   = 0;
    m_c1   = 0;
    sb.delete();
    exp_bytes = fq;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; rd_ack = 2'b00; fifo_data_rdy = 1'b0; bist_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    reset_tail();
  endtask

  task automatic txn(input logic [1:0] r, input int dly, input int stalls,
                     input bit stall_bist, input bit drop, input bit wrong, input bit lat);
    int         cyc, pop_n, first_pop, last_pop, vcyc, left;
    logic [1:0] w;
    if (exp_bytes.size() == 0) write_byte(DATA_BITS'($urandom));
    predict(r);
    w = sb[$].win;
    req = r; cyc = 0; pop_n = 0; first_pop = 0; last_pop = 0; vcyc = -1; left = stalls;
    while (vcyc < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (fifo_pop) begin
        if (pop_n == 0) first_pop = cyc;
        pop_n++;
        last_pop = cyc;
      end
      if (rd_valid) vcyc = cyc;
      #1;
      fifo_data_rdy = 1'b0;
      bist_mode     = 1'b0;
      if (fifo_pop && drop) req = 2'b00;
      if (fifo_pop && left > 0) begin
        left--;
        if (stall_bist) bist_mode = 1'b1;
        else begin
          fifo_data_rdy = 1'b1;
          wdata = DATA_BITS'($urandom);
          exp_bytes.push_back(wdata);
        end
      end
      if (rd_valid) rd_ack = (dly == 0) ? w : (wrong ? ~w : 2'b00);
      else          rd_ack = wrong ? 2'($urandom) : 2'b00;
    end
    chk("rd_valid_within_budget", (vcyc >= 0), 1);
    if (vcyc < 0) begin
      rd_ack = 2'b00;
      return;
    end
    chk("pop_cycles", pop_n, stalls + 1);
    chk("pop_to_valid_latency", vcyc - last_pop, 2);
    if (lat) chk("req_to_pop_latency", first_pop, 1);
    for (int i = 1; i <= dly; i++) begin
      @(negedge clk);
      chk("valid_held_before_ack", rd_valid, 1);
      #1;
      rd_ack = (i == dly) ? w : (wrong ? ~w : 2'b00);
    end
    @(negedge clk);
    chk("valid_drop_after_ack", rd_valid, 0);
    #1;
    rd_ack = 2'b00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; req = 2'b00; rd_ack = 2'b00; fifo_data_rdy = 1'b0; bist_mode = 1'b0; wdata = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_fifo_pop", fifo_pop, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    reset_tail();

    // Three bytes, both requesting, instant ack: grants alternate 01,10,01.
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    for (int i = 0; i < 3; i++) txn(2'b11, 0, 0, 0, 0, 0, 0);
    req = 2'b00;

    // Single byte, latency from request to pop and to delivery.
    do_reset();
    write_byte(8'hA5);
    txn(2'b01, 0, 0, 0, 0, 0, 1);

    // Empty FIFO: no pop until a byte arrives, then pop right after.
    req = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("empty_no_pop", fifo_pop, 0);
    end
    #1;
    write_byte(8'h5C);
    txn(2'b10, 0, 0, 0, 0, 0, 1);

    // BIST in IDLE blocks the pop.
    req = 2'b00;
    write_byte(8'h77);
    bist_mode = 1'b1;
    req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bist_idle_no_pop", fifo_pop, 0);
    end
    #1;
    bist_mode = 1'b0;
    txn(2'b01, 0, 0, 0, 0, 0, 1);

    // Write strobe during POP for three cycles, then BIST stalls.
    txn(2'b01, 1, 3, 0, 0, 0, 0);
    txn(2'b10, 0, 2, 1, 0, 0, 0);

    // Wrong-bit acks for five cycles with the request dropped.
    txn(2'b10, 5, 0, 0, 1, 1, 0);

    // Randomised transactions.
    for (int i = 0; i < 30; i++) begin
      txn(2'(1 + $urandom % 3), $urandom % 4, $urandom % 3, 1'($urandom),
          1'($urandom), 1'($urandom), 0);
      if ($urandom % 2) req = 2'b00;
    end
    req = 2'b00;

    // Asynchronous reset while a byte is being offered.
    write_byte(8'h3C);
    predict(2'b01);
    req = 2'b01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_valid && n < 60);
    chk("reached_deliver_before_rst", rd_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_fifo_pop", fifo_pop, 0);
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_rd_valid", rd_valid, 0);
    chk("async_rst_rd_data", rd_data, 0);
    chk("async_rst_cnt0", cnt0, 0);
    chk("async_rst_cnt1", cnt1, 0);
    req = 2'b00;
    @(negedge clk);
    #1 rst = 1'b0;
    reset_tail();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_pop_after_rst", fifo_pop, 0);
    end
    #1;
    txn(2'b11, 0, 0, 0, 0, 0, 0);

    // Drive requester 0 past counter saturation.
    for (int i = 0; i < CMAX + 2; i++) txn(2'b01, 0, 0, 0, 0, 0, 0);
    req = 2'b00;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
